// File: rtl/icache_mem_responder.sv
// Backing-store responder for the instruction cache: accepts one-word fetches,
// waits LATENCY cycles, then returns the word from a preloadable array.
module icache_mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 4096,
    parameter int                    LATENCY    = 4,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         mem_ready,
    output logic                         mem_err,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]        load_data,
    output logic                         busy,
    output logic [31:0]                  req_count
);

    localparam int IDX   = $clog2(MEM_DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   saved_addr_q, saved_addr_d;
    logic [31:0]             req_count_q, req_count_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic                    mem_ready_q, mem_ready_d;
    logic                    mem_err_q, mem_err_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   resp_addr;
    logic [IDX-1:0]          rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    out_of_range;
    logic                    resp_now;

    // With LATENCY=1 the response is built straight from the incoming address.
    always_comb begin
        resp_addr    = (state_q == S_IDLE) ? mem_addr : saved_addr_q;
        rd_idx       = resp_addr[IDX+1:2];
        out_of_range = (resp_addr >> (IDX + 2)) != '0;
        // A preload landing on the same edge that enters RESP must be seen.
        rd_word      = (load_en && load_addr == rd_idx) ? load_data : mem_q[rd_idx];
    end

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        saved_addr_d = saved_addr_q;
        req_count_d  = req_count_q;
        mem_data_d   = mem_data_q;
        mem_ready_d  = 1'b0;
        mem_err_d    = 1'b0;
        resp_now     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    saved_addr_d = mem_addr;
                    cnt_d        = CNT_W'(LATENCY - 1);
                    if (req_count_q != '1) begin
                        req_count_d = req_count_q + 32'd1;
                    end
                    if (LATENCY == 1) begin
                        state_d  = S_RESP;
                        resp_now = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    state_d  = S_RESP;
                    resp_now = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (resp_now) begin
            mem_ready_d = 1'b1;
            mem_err_d   = out_of_range;
            mem_data_d  = out_of_range ? ERR_DATA : rd_word;
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            saved_addr_q <= '0;
            req_count_q  <= '0;
            mem_data_q   <= '0;
            mem_ready_q  <= 1'b0;
            mem_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            saved_addr_q <= saved_addr_d;
            req_count_q  <= req_count_d;
            mem_data_q   <= mem_data_d;
            mem_ready_q  <= mem_ready_d;
            mem_err_q    <= mem_err_d;
            busy_q       <= busy_d;
        end
    end

    // NOTE: the array has no reset; contents survive rst and come only from preload.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign mem_data  = mem_data_q;
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign busy      = busy_q;
    assign req_count = req_count_q;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed bench for icache_mem_responder: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for the direct IDLE-to-RESP path.
module tb_icache_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        mem_err;
    logic        load_en;
    logic [11:0] load_addr;
    logic [31:0] load_data;
    logic        busy;
    logic [31:0] req_count;

    logic        req1;
    logic [31:0] addr1;
    logic [31:0] data1;
    logic        ready1;
    logic        err1;
    logic        busy1;
    logic [31:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    icache_mem_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ready(mem_ready), .mem_err(mem_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy), .req_count(req_count)
    );

    icache_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_addr(addr1),
        .mem_data(data1), .mem_ready(ready1), .mem_err(err1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy1), .req_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Issue one fetch from IDLE; mem_req is held for `hold` cycles after acceptance.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_d, input logic exp_e, input int hold);
        int cyc;
        mem_req  = 1'b1;
        mem_addr = addr;
        tick();
        exp_count++;
        check({tag, "_busy_start"}, busy, 1);
        cyc = 1;
        while (!mem_ready && cyc < 20) begin
            if (cyc >= hold) mem_req = 1'b0;
            tick();
            cyc++;
        end
        mem_req = 1'b0;
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_data"}, mem_data, exp_d);
        check({tag, "_err"}, mem_err, exp_e);
        check({tag, "_busy_resp"}, busy, 1);
        check({tag, "_count"}, req_count, exp_count);
        tick();
        check({tag, "_ready_drop"}, mem_ready, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int   cyc;
        int   first;
        int   second;
        logic seen;

        rst = 1'b1; mem_req = 1'b0; mem_addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        req1 = 1'b0; addr1 = '0;
        repeat (3) tick();
        check("rst_ready", mem_ready, 0);
        check("rst_err", mem_err, 0);
        check("rst_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_count", req_count, 0);
        rst = 1'b0;

        preload(12'd5, 32'h1234_5678);
        preload(12'd7, 32'hAAAA_AAAA);
        preload(12'd4095, 32'h0F0F_0F0F);
        for (int i = 0; i < 4; i++) preload(12'(i), 32'hC0DE_0000 + 32'(i));

        fetch("single", 32'h14, 32'h1234_5678, 1'b0, 1);
        fetch("oor", 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 1);
        fetch("top_word", 32'h0000_3FFC, 32'h0F0F_0F0F, 1'b0, 1);
        fetch("low_bits", 32'h17, 32'h1234_5678, 1'b0, 1);

        // Preload on the edge entering RESP is visible.
        mem_req = 1'b1; mem_addr = 32'h1C;
        tick();
        exp_count++;
        mem_req = 1'b0;
        tick(); tick();
        load_en = 1'b1; load_addr = 12'd7; load_data = 32'hBBBB_BBBB;
        tick();
        load_en = 1'b0;
        check("race_edge_ready", mem_ready, 1);
        check("race_edge_data", mem_data, 32'hBBBB_BBBB);
        tick();

        // Preload during RESP is not visible in that response.
        preload(12'd7, 32'hAAAA_AAAA);
        mem_req = 1'b1; mem_addr = 32'h1C;
        tick();
        exp_count++;
        mem_req = 1'b0;
        tick(); tick(); tick();
        check("race_late_ready", mem_ready, 1);
        load_en = 1'b1; load_addr = 12'd7; load_data = 32'hBBBB_BBBB;
        check("race_late_data", mem_data, 32'hAAAA_AAAA);
        tick();
        load_en = 1'b0;
        check("race_late_drop", mem_ready, 0);
        fetch("race_commit", 32'h1C, 32'hBBBB_BBBB, 1'b0, 1);

        rst = 1'b1; tick(); rst = 1'b0;
        exp_count = 0;
        fetch("withdrawn", 32'h14, 32'h1234_5678, 1'b0, 2);

        // Back-to-back: request held high across the first response.
        mem_req = 1'b1; mem_addr = 32'h14;
        cyc = 0; first = -1; second = -1;
        while (second < 0 && cyc < 40) begin
            tick();
            cyc++;
            if (mem_ready) begin
                if (first < 0) begin
                    first = cyc;
                    check("b2b_first_data", mem_data, 32'h1234_5678);
                    mem_addr = 32'h1C;
                end else begin
                    second = cyc;
                    check("b2b_second_data", mem_data, 32'hBBBB_BBBB);
                    mem_req = 1'b0;
                end
            end
        end
        mem_req = 1'b0;
        exp_count += 2;
        check("b2b_first_at", first, LAT);
        check("b2b_spacing", second - first, LAT + 1);
        check("b2b_count", req_count, 3);
        tick();

        // Reset two cycles after acceptance kills the transaction.
        mem_req = 1'b1; mem_addr = 32'h14;
        tick();
        mem_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_ready", mem_ready, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_count", req_count, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | mem_ready;
        end
        check("rstmid_no_ready", seen, 0);
        exp_count = 0;
        fetch("rstmid_refetch", 32'h14, 32'h1234_5678, 1'b0, 1);

        // LATENCY=1 instance: response in the cycle right after acceptance.
        for (int i = 0; i < 4; i++) begin
            req1  = 1'b1;
            addr1 = 32'(i * 4);
            tick();
            check("l1_ready", ready1, 1);
            check("l1_data", data1, 32'hC0DE_0000 + 32'(i));
            check("l1_err", err1, 0);
            check("l1_busy", busy1, 1);
            req1 = 1'b0;
            tick();
            check("l1_ready_drop", ready1, 0);
            check("l1_idle", busy1, 0);
        end
        check("l1_count", cnt1, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_mem_responder.md
# icache_mem_responder

Instruction-memory responder for the memory side of the instruction cache. It accepts single-word fetch requests over the `mem_req`/`mem_addr`/`mem_data`/`mem_ready` handshake, waits a programmable number of cycles, then returns the word from an internal word-addressed array. The testbench or boot loader fills the array through a preload write port. The block sits between the cache and the system bus model and serves as the cache's backing store in simulation and FPGA bring-up.

## Interface
- `ADDR_WIDTH`, 32: byte-address width.
- `DATA_WIDTH`, 32: word width.
- `MEM_DEPTH`, 4096: words in the backing array; power of two, at least 2.
- `LATENCY`, 4: cycles from request acceptance to `mem_ready`; minimum 1.
- `ERR_DATA`, 32'hDEAD_BEEF: data returned for out-of-range addresses.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `mem_req` input 1: fetch request from the cache.
- `mem_addr` input ADDR_WIDTH: byte address; bits [1:0] are ignored.
- `mem_data` output DATA_WIDTH: response word; valid only while `mem_ready`=1.
- `mem_ready` output 1: one-cycle response strobe.
- `mem_err` output 1: one-cycle pulse, coincident with `mem_ready`, for an out-of-range address.
- `load_en` input 1: preload write enable.
- `load_addr` input $clog2(MEM_DEPTH): preload word index.
- `load_data` input DATA_WIDTH: preload word.
- `busy` output 1: high whenever the state is not IDLE.
- `req_count` output 32: number of accepted requests; saturates at 32'hFFFF_FFFF.

## Operation
- The state machine has three states: IDLE, WAIT and RESP.
- **IDLE:** if `mem_req`=1, accept the request:
  - latch `mem_addr` as `saved_addr`;
  - load the latency counter with LATENCY-1;
  - increment `req_count` (saturating);
  - go to WAIT, or go directly to RESP when LATENCY=1.
- **WAIT:** decrement the counter each cycle. When the counter reaches 0, register the response and go to RESP.
- **RESP:** `mem_ready`=1 for exactly this cycle, then return to IDLE unconditionally.
- **Response data:**
  - The word index is `saved_addr[IDX+1:2]`, where IDX=$clog2(MEM_DEPTH).
  - The address is out of range if any of `saved_addr[ADDR_WIDTH-1:IDX+2]` is nonzero. In that case `mem_data`=ERR_DATA and `mem_err`=1.
- **Data sampling:** the array is read on the clock edge that enters RESP. A preload write committed on any earlier edge, including the edge entering RESP, is visible in the response; a write in the RESP cycle itself is not.
- **Preload:** `load_en`=1 writes `load_data` to `mem[load_addr]` on the edge, in any state. It never stalls or alters an in-flight request.
- **Request ignored while busy:** the cache drops `mem_req` combinationally in the same cycle it sees `mem_ready`. `mem_req` is therefore ignored in WAIT and RESP, and `mem_ready` must not depend combinationally on `mem_req`; both outputs are registered.
- **Request withdrawn:** if `mem_req` falls during WAIT, the transaction still completes and `mem_ready` still pulses. There is no abort.
- **Back-to-back requests:** a request held high in the cycle after RESP is accepted as a new transaction.

## Timing
- **Reset values:** `mem_ready`=0, `mem_err`=0, `mem_data`=0, `busy`=0, `req_count`=0, state=IDLE, counter=0.
- Array contents are not reset.
- **Reset mid-transaction:** asserting `rst` during WAIT or RESP returns to IDLE on that edge and suppresses any pending `mem_ready`.
- **Latency:** `mem_req` sampled high in IDLE at edge t gives `mem_ready`=1 during cycle t+LATENCY. `busy` is high from cycle t+1 through t+LATENCY.
- `mem_data` holds its last value outside RESP. The verifier must check it only when `mem_ready`=1.
- **Throughput:** at most one response every LATENCY+1 cycles. Against the cache, whose ALLOCATE state adds one more cycle, the miss penalty is LATENCY+2 cycles from the miss cycle to `cpu_valid`.
- **Counter wrap:** the counter is never loaded above LATENCY-1 and never underflows. `req_count` holds at all-ones.

## Test plan
- **Single fetch:**
  - Preload mem[5]=32'h1234_5678, LATENCY=4.
  - Assert `mem_req` with `mem_addr`=32'h14 at edge 10.
  - Expect `mem_ready`=1 only in cycle 14, `mem_data`=32'h1234_5678, `mem_err`=0, `busy` high in cycles 11–14, `req_count`=1.
- **Out-of-range address:**
  - With MEM_DEPTH=4096, request `mem_addr`=32'h0000_4000.
  - Expect `mem_ready` and `mem_err` together for one cycle, with `mem_data`=32'hDEAD_BEEF.
- **Preload race:**
  - Request word 7 (initially 32'hAAAA_AAAA).
  - Write `load_data`=32'hBBBB_BBBB to index 7 on the edge entering RESP; expect the response to be 32'hBBBB_BBBB.
  - Repeat with the write one cycle later; expect 32'hAAAA_AAAA.
- **Withdrawn request and back-to-back:**
  - Drop `mem_req` two cycles after acceptance; expect `mem_ready` still at t+LATENCY.
  - Then hold `mem_req` continuously for two addresses; expect a second acceptance in the cycle after RESP, responses LATENCY+1 cycles apart, and `req_count`=3.
- **Reset mid-WAIT:**
  - Assert `rst` two cycles after acceptance.
  - Expect no `mem_ready`, `busy`=0 and `req_count`=0 on the following cycle, with array contents intact on a subsequent fetch.
- **Closed loop with the cache, LATENCY=1 and LATENCY=8:**
  - Run a sequential fetch of 16 words, then a refetch.
  - Expect 16 misses with `cpu_valid` LATENCY+2 cycles after each miss request, then 16 single-cycle hits with matching data.
